// File: rtl/fwd_pkg.sv
// fwd_pkg: shared types and constants for the forwarding/hazard unit
package fwd_pkg;
    localparam int FWD_REG_AW  = 5;
    localparam int FWD_LAT_W   = 2;
    localparam int SEL_REGFILE = 0;
    localparam int LAT_ALU     = 1;
    localparam int LAT_LOAD    = 2;
    typedef struct packed {
        logic                  valid;
        logic                  wr;
        logic [FWD_REG_AW-1:0] rd;
        logic [FWD_LAT_W-1:0]  cnt;
    } fwd_entry_t;
endpackage

// File: rtl/fwd_match.sv
// fwd_match: youngest-producer search for one source operand over the scoreboard entries
module fwd_match
    import fwd_pkg::*;
#(
    parameter int REG_AW = 5,
    parameter int DEPTH  = 3,
    parameter int LAT_W  = 2,
    parameter int SEL_W  = $clog2(DEPTH + 2)
) (
    input  logic [DEPTH-1:0]        valid,
    input  logic [DEPTH-1:0]        wr,
    input  logic [DEPTH*REG_AW-1:0] rd,
    input  logic [DEPTH*LAT_W-1:0]  cnt,
    input  logic [REG_AW-1:0]       src,
    input  logic                    en,
    output logic                    hit,
    output logic [SEL_W-1:0]        sel,
    output logic                    not_ready
);
    // oldest first so a younger match overwrites an older one
    always_comb begin
        hit = 1'b0;
        sel = SEL_W'(SEL_REGFILE);
        not_ready = 1'b0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (en && valid[k] && wr[k] && rd[k*REG_AW +: REG_AW] != '0
                && rd[k*REG_AW +: REG_AW] == src) begin
                hit = 1'b1;
                sel = SEL_W'(k + 2);
                not_ready = cnt[k*LAT_W +: LAT_W] > LAT_W'(1);
            end
        end
    end
endmodule

// File: rtl/fwd_hazard_scoreboard.sv
// fwd_hazard_scoreboard: in-flight writer scoreboard driving EX forward selects,
// IF/ID stalls for not-yet-forwardable producers, and a saturating stall counter
module fwd_hazard_scoreboard
    import fwd_pkg::*;
#(
    parameter int REG_AW  = 5,
    parameter int NUM_SRC = 2,
    parameter int DEPTH   = 3,
    parameter int LAT_W   = 2
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic                                 id_valid_i,
    input  logic [NUM_SRC*REG_AW-1:0]            id_src_i,
    input  logic [NUM_SRC-1:0]                   id_src_en_i,
    input  logic                                 id_wr_i,
    input  logic [REG_AW-1:0]                    id_rd_i,
    input  logic [LAT_W-1:0]                     id_lat_i,
    input  logic                                 flush_i,
    output logic                                 stall_o,
    output logic [NUM_SRC*$clog2(DEPTH+2)-1:0]   fwd_sel_o,
    output logic [15:0]                          stall_cnt_o
);
    localparam int SEL_W = $clog2(DEPTH + 2);

    typedef struct packed {
        logic              valid;
        logic              wr;
        logic [REG_AW-1:0] rd;
        logic [LAT_W-1:0]  cnt;
    } entry_t;

    // e[0] is EX, e[DEPTH-1] the oldest tracked stage
    entry_t e [DEPTH];

    logic [DEPTH-1:0]         e_valid;
    logic [DEPTH-1:0]         e_wr;
    logic [DEPTH*REG_AW-1:0]  e_rd;
    logic [DEPTH*LAT_W-1:0]   e_cnt;
    logic [NUM_SRC-1:0]       hit;
    logic [NUM_SRC-1:0]       not_ready;
    logic [NUM_SRC*SEL_W-1:0] sel;
    logic [NUM_SRC-1:0]       hazard;
    logic                     adv;
    logic [LAT_W-1:0]         lat_eff;

    for (genvar k = 0; k < DEPTH; k++) begin : g_flat
        assign e_valid[k]               = e[k].valid;
        assign e_wr[k]                  = e[k].wr;
        assign e_rd[k*REG_AW +: REG_AW] = e[k].rd;
        assign e_cnt[k*LAT_W +: LAT_W]  = e[k].cnt;
    end

    for (genvar j = 0; j < NUM_SRC; j++) begin : g_src
        fwd_match #(
            .REG_AW(REG_AW),
            .DEPTH (DEPTH),
            .LAT_W (LAT_W),
            .SEL_W (SEL_W)
        ) u_match (
            .valid    (e_valid),
            .wr       (e_wr),
            .rd       (e_rd),
            .cnt      (e_cnt),
            .src      (id_src_i[j*REG_AW +: REG_AW]),
            .en       (id_src_en_i[j]),
            .hit      (hit[j]),
            .sel      (sel[j*SEL_W +: SEL_W]),
            .not_ready(not_ready[j])
        );
        assign hazard[j] = id_valid_i && hit[j] && not_ready[j];
    end

    // rst_i gating keeps stall low while the entries are being cleared
    assign stall_o = rst_i && |hazard && !flush_i;
    assign adv     = !stall_o && !flush_i;
    assign lat_eff = id_lat_i == '0 ? LAT_W'(LAT_ALU) : id_lat_i;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            for (int k = 0; k < DEPTH; k++) e[k] <= '0;
            fwd_sel_o   <= '0;
            stall_cnt_o <= '0;
        end else begin
            e[0].valid <= adv && id_valid_i;
            e[0].wr    <= id_wr_i;
            e[0].rd    <= id_rd_i;
            e[0].cnt   <= adv ? lat_eff : '0;
            for (int k = 1; k < DEPTH; k++) begin
                e[k].valid <= e[k-1].valid;
                e[k].wr    <= e[k-1].wr;
                e[k].rd    <= e[k-1].rd;
                e[k].cnt   <= e[k-1].cnt - LAT_W'(e[k-1].cnt != '0);
            end
            fwd_sel_o   <= adv ? sel : '0;
            stall_cnt_o <= stall_cnt_o + {15'd0, stall_o && stall_cnt_o != 16'hFFFF};
        end
    end
endmodule

// File: tb/tb_fwd_hazard_scoreboard.sv
// tb_fwd_hazard_scoreboard: directed scenarios plus random traffic checked against a
// timestamp-style model (producer in stage k is forwardable for the consumer iff lat <= k)
module tb_fwd_hazard_scoreboard;
    localparam int REG_AW  = 5;
    localparam int NUM_SRC = 2;
    localparam int DEPTH   = 3;
    localparam int LAT_W   = 2;
    localparam int SEL_W   = 3;

    logic                        clk_i = 1'b0;
    logic                        rst_i = 1'b0;
    logic                        id_valid_i = 1'b0;
    logic [NUM_SRC*REG_AW-1:0]   id_src_i = '0;
    logic [NUM_SRC-1:0]          id_src_en_i = '0;
    logic                        id_wr_i = 1'b0;
    logic [REG_AW-1:0]           id_rd_i = '0;
    logic [LAT_W-1:0]            id_lat_i = '0;
    logic                        flush_i = 1'b0;
    logic                        stall_o;
    logic [NUM_SRC*SEL_W-1:0]    fwd_sel_o;
    logic [15:0]                 stall_cnt_o;

    int checks = 0;
    int failures = 0;
    bit rst_nxt = 1'b1;

    fwd_hazard_scoreboard #(
        .REG_AW (REG_AW),
        .NUM_SRC(NUM_SRC),
        .DEPTH  (DEPTH),
        .LAT_W  (LAT_W)
    ) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .id_valid_i (id_valid_i),
        .id_src_i   (id_src_i),
        .id_src_en_i(id_src_en_i),
        .id_wr_i    (id_wr_i),
        .id_rd_i    (id_rd_i),
        .id_lat_i   (id_lat_i),
        .flush_i    (flush_i),
        .stall_o    (stall_o),
        .fwd_sel_o  (fwd_sel_o),
        .stall_cnt_o(stall_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    // model: queue of instructions that entered EX, youngest at index 0
    typedef struct {
        bit v;
        bit w;
        int rd;
        int lat;
    } rec_t;
    rec_t m_q[$];
    int   m_sel [NUM_SRC];
    int   m_cnt = 0;
    bit   m_init = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_eval(output bit st, output int sel [NUM_SRC]);
        int  s;
        bit  found;
        st = 1'b0;
        for (int j = 0; j < NUM_SRC; j++) begin
            s = int'(id_src_i[j*REG_AW +: REG_AW]);
            found = 1'b0;
            sel[j] = 0;
            for (int k = 0; k < m_q.size(); k++) begin
                if (!found && id_src_en_i[j] && m_q[k].v && m_q[k].w && m_q[k].rd != 0 && m_q[k].rd == s) begin
                    found = 1'b1;
                    sel[j] = k + 2;
                    // consumer reaches EX k+1 cycles after the producer entered it
                    if (id_valid_i && m_q[k].lat > k + 1) st = 1'b1;
                end
            end
        end
        if (flush_i || !rst_i) st = 1'b0;
    endfunction

    always @(posedge clk_i) begin
        bit   st;
        int   sel [NUM_SRC];
        rec_t r;
        if (!rst_i) begin
            m_q.delete();
            for (int k = 0; k < DEPTH; k++) m_q.push_back('{v: 1'b0, w: 1'b0, rd: 0, lat: 0});
            for (int j = 0; j < NUM_SRC; j++) m_sel[j] = 0;
            m_cnt = 0;
            m_init = 1'b1;
        end else if (m_init) begin
            model_eval(st, sel);
            r = '{v: 1'b0, w: 1'b0, rd: 0, lat: 0};
            if (!st && !flush_i)
                r = '{v: id_valid_i, w: id_wr_i, rd: int'(id_rd_i), lat: (id_lat_i == 0) ? 1 : int'(id_lat_i)};
            m_q.push_front(r);
            void'(m_q.pop_back());
            for (int j = 0; j < NUM_SRC; j++) m_sel[j] = (!st && !flush_i) ? sel[j] : 0;
            if (st && m_cnt < 65535) m_cnt++;
        end
    end

    always @(negedge clk_i) begin
        bit st;
        int sel [NUM_SRC];
        if (m_init) begin
            model_eval(st, sel);
            chk("model_stall", int'(stall_o), int'(st));
            for (int j = 0; j < NUM_SRC; j++)
                chk("model_sel", int'(fwd_sel_o[j*SEL_W +: SEL_W]), m_sel[j]);
            chk("model_cnt", int'(stall_cnt_o), m_cnt);
        end
    end

    task automatic issue(input bit v, input bit w, input int rd, input int lat,
                         input int s0, input int s1, input bit [1:0] en, input bit fl);
        @(posedge clk_i);
        #1;
        rst_i       = rst_nxt;
        id_valid_i  = v;
        id_wr_i     = w;
        id_rd_i     = REG_AW'(rd);
        id_lat_i    = LAT_W'(lat);
        id_src_i    = {REG_AW'(s1), REG_AW'(s0)};
        id_src_en_i = en;
        flush_i     = fl;
        @(negedge clk_i);
    endtask

    task automatic nop();
        issue(0, 0, 0, 0, 0, 0, 2'b00, 0);
    endtask

    task automatic reset_dut();
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        id_valid_i = 0; id_wr_i = 0; id_rd_i = '0; id_lat_i = '0;
        id_src_i = '0; id_src_en_i = '0; flush_i = 0;
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 1'b1;
        @(negedge clk_i);
    endtask

    function automatic int sel_of(input int j);
        return int'(fwd_sel_o[j*SEL_W +: SEL_W]);
    endfunction

    initial begin
        reset_dut();
        chk("reset_stall", int'(stall_o), 0);
        chk("reset_sel", int'(fwd_sel_o), 0);
        chk("reset_cnt", int'(stall_cnt_o), 0);

        // ALU producer, back-to-back consumer
        issue(1, 1, 3, 1, 0, 0, 2'b00, 0);
        issue(1, 1, 4, 1, 3, 5, 2'b11, 0);
        chk("alu_stall", int'(stall_o), 0);
        nop();
        chk("alu_sel0", sel_of(0), 2);
        chk("alu_sel1", sel_of(1), 0);

        // load-use
        reset_dut();
        issue(1, 1, 3, 2, 0, 0, 2'b00, 0);
        issue(1, 1, 6, 1, 3, 3, 2'b11, 0);
        chk("load_stall", int'(stall_o), 1);
        issue(1, 1, 6, 1, 3, 3, 2'b11, 0);
        chk("load_release", int'(stall_o), 0);
        chk("load_cnt", int'(stall_cnt_o), 1);
        nop();
        chk("load_sel0", sel_of(0), 3);
        chk("load_sel1", sel_of(1), 3);

        // youngest producer wins
        issue(1, 1, 3, 1, 0, 0, 2'b00, 0);
        issue(1, 1, 3, 1, 0, 0, 2'b00, 0);
        issue(1, 1, 8, 1, 3, 0, 2'b01, 0);
        chk("young_stall", int'(stall_o), 0);
        nop();
        chk("young_sel", sel_of(0), 2);

        // r0 never forwards
        issue(1, 1, 0, 2, 0, 0, 2'b00, 0);
        issue(1, 1, 9, 1, 0, 0, 2'b11, 0);
        chk("r0_stall", int'(stall_o), 0);
        nop();
        chk("r0_sel0", sel_of(0), 0);
        chk("r0_sel1", sel_of(1), 0);

        // lat=3 producer: flush during second stall cycle
        reset_dut();
        issue(1, 1, 7, 3, 0, 0, 2'b00, 0);
        issue(1, 1, 10, 1, 7, 0, 2'b01, 0);
        chk("mul_stall1", int'(stall_o), 1);
        issue(1, 1, 10, 1, 7, 0, 2'b01, 1);
        chk("mul_flush_stall", int'(stall_o), 0);
        nop();
        chk("mul_flush_sel", sel_of(0), 0);
        chk("mul_flush_cnt", int'(stall_cnt_o), 1);

        // lat=3 producer without flush: two stall cycles then forward from stage 3
        issue(1, 1, 7, 3, 0, 0, 2'b00, 0);
        issue(1, 1, 10, 1, 7, 0, 2'b01, 0);
        chk("mul_s1", int'(stall_o), 1);
        issue(1, 1, 10, 1, 7, 0, 2'b01, 0);
        chk("mul_s2", int'(stall_o), 1);
        issue(1, 1, 10, 1, 7, 0, 2'b01, 0);
        chk("mul_s3", int'(stall_o), 0);
        chk("mul_cnt", int'(stall_cnt_o), 3);
        nop();
        chk("mul_sel", sel_of(0), 4);

        // reset mid-operation
        issue(1, 1, 9, 2, 0, 0, 2'b00, 0);
        rst_nxt = 1'b0;
        issue(1, 1, 11, 1, 9, 9, 2'b11, 0);
        chk("midrst_stall", int'(stall_o), 0);
        rst_nxt = 1'b1;
        issue(1, 1, 11, 1, 9, 9, 2'b11, 0);
        chk("postrst_stall", int'(stall_o), 0);
        chk("postrst_sel", int'(fwd_sel_o), 0);
        chk("postrst_cnt", int'(stall_cnt_o), 0);
        nop();
        chk("postrst_sel2", int'(fwd_sel_o), 0);

        // random traffic over a small register set to provoke matches
        for (int i = 0; i < 3000; i++) begin
            rst_nxt = ($urandom_range(199) != 0);
            issue($urandom_range(7) != 0, $urandom_range(3) != 0,
                  int'($urandom_range(3)), int'($urandom_range(3)),
                  int'($urandom_range(3)), int'($urandom_range(3)),
                  2'($urandom_range(3)), $urandom_range(9) == 0);
        end
        rst_nxt = 1'b1;
        nop();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
